regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Multi-port integer register file for the pipelined core. Generalises the single-cycle file:
//  parametrised width/depth/read ports, two write ports, stack-pointer reset value and a
//  per-register busy scoreboard. Decode reads it, writeback writes it, issue marks producers.
// PARAMETERS
//  DATA_W       32      register width in bits
//  ADDR_W       5       address width; depth = 2**ADDR_W; register 0 hardwired to zero
//  NUM_RD       2       number of combinational read ports (1..4)
//  SP_IDX       29      index of stack-pointer register
//  STACK_START  'hfff   reset value of register SP_IDX; all other registers reset to 0
// PORTS
//  CLK      in   1              clock, all state updates on rising edge
//  RST      in   1              reset, synchronous, active-high
//  raddr    in   NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
//  rdata    out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
//  rbusy    out  NUM_RD         1 = register on port p has an outstanding producer
//  wen0/wen1   in 1             write enables, port 0 and port 1
//  waddr0/waddr1 in ADDR_W      write addresses
//  wdata0/wdata1 in DATA_W      write data
//  iss_en   in   1              issue: mark iss_addr busy
//  iss_addr in   ADDR_W         destination register of issued instruction
// BEHAVIOUR
//  - Reset is synchronous, active-high: on a rising CLK with RST=1, every register = 0 except
//    reg[SP_IDX] = STACK_START; every busy bit = 0. Writes and issues that cycle are ignored.
//    RST dominates all other inputs in the same cycle. rdata follows the reset contents in the
//    following cycle. rbusy reads 0 after reset.
//  - Reads are combinational, zero latency: rdata[p] = reg[raddr[p]]. Address 0 always reads 0
//    and is never busy.
//  - Writes commit on the rising edge. Writes to address 0 are discarded. wen0 and wen1 to the same
//    address in the same cycle: port 1 wins and port 0 data is lost.
//  - Scoreboard: iss_en=1 with iss_addr!=0 sets busy[iss_addr] at the edge. Any committed write
//    clears busy[waddr]. If issue and write target the same address in one cycle, issue wins and
//    busy stays 1 (the new producer supersedes the old one).
//  - rbusy[p] = busy[raddr[p]] (see CONFIGURATION for bypass qualification).
//  - No internal state machine beyond the register and busy arrays. All outputs are pure
//    functions of state plus the current-cycle inputs.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-to-read forwarding. If raddr[p]!=0 matches an enabled write
//    this cycle, rdata[p] = that wdata (port 1 over port 0) and rbusy[p] = 0 unless iss_en also
//    targets it. The bypass path is combinational.
//  Undefined: reads return the pre-edge contents. rbusy is the raw busy bit. Writeback must then
//    precede decode by one cycle.
// STRUCTURE
//  - Package regfile_pkg: DATA_W/ADDR_W defaults, SP_IDX, STACK_START, and a reg_addr_t typedef.
//  - One sub-module, regfile_rd_port: read mux plus optional bypass/busy qualification.
//    It is instantiated NUM_RD times in a generate loop.
//  - Storage and scoreboard stay in regfile_mp.
// TESTING
//  1 Reset: RST=1 for one edge. Then read reg 29 -> 'hfff, reg 5 -> 0, all rbusy=0.
//    Also: RST=1 together with wen0 to reg 5 = 7 -> reg 5 reads 0.
//  2 Write/read reg0: wen0 waddr0=0 wdata0='hdead -> reg 0 reads 0.
//    wen0 waddr0=3 wdata0=42 -> next cycle, both read ports at addr 3 read 42.
//  3 Write collision: wen0/wen1 both to reg 7, data 1 and 2 -> reg 7 reads 2.
//  4 Scoreboard: iss_en addr 8 -> rbusy=1 for addr 8. Write 8 -> rbusy=0.
//    Issue and write to 8 in the same cycle -> rbusy stays 1.
//  5 Bypass (REGFILE_BYPASS_EN): reg 4 = 9, then in one cycle wen1 addr 4 = 11 with raddr=4
//    -> same cycle rdata=11. Without the macro, rdata=9 that cycle and 11 the next.
//  6 Random: 2000 cycles of random wen/iss/raddr with RST pulses mid-run.
//    Compare every cycle against a reference model of registers plus busy bits.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port integer register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

    localparam int unsigned RF_DATA_W      = 32;
    localparam int unsigned RF_ADDR_W      = 5;
    localparam int unsigned RF_NUM_RD      = 2;
    localparam int unsigned RF_SP_IDX      = 29;
    localparam int unsigned RF_STACK_START = 32'h0000_0fff;

    typedef logic [RF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: register mux, zero-register masking and busy lookup.
// With REGFILE_BYPASS_EN defined, same-cycle writes are forwarded to the read data.
module regfile_rd_port #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [2**ADDR_W-1:0] busy,
`ifdef REGFILE_BYPASS_EN
    input  logic              wen0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              rbusy
);

    // Read select; port 1 forwarding overrides port 0 when both hit the same register
    always_comb begin
        rdata = regs[raddr];
        rbusy = busy[raddr];
`ifdef REGFILE_BYPASS_EN
        if (wen0 && (waddr0 == raddr)) begin
            rdata = wdata0;
            rbusy = iss_en && (iss_addr == raddr);
        end
        if (wen1 && (waddr1 == raddr)) begin
            rdata = wdata1;
            rbusy = iss_en && (iss_addr == raddr);
        end
`endif
        if (raddr == '0) begin
            rdata = '0;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with two write ports and a per-register busy scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding in each read port).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W      = RF_DATA_W,
    parameter int unsigned ADDR_W      = RF_ADDR_W,
    parameter int unsigned NUM_RD      = RF_NUM_RD,
    parameter int unsigned SP_IDX      = RF_SP_IDX,
    parameter int unsigned STACK_START = RF_STACK_START
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     wen0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     wen1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Storage and scoreboard update; later statements win (port 1 over port 0, issue over write)
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == SP_IDX) ? DATA_W'(STACK_START) : '0;
            end
            busy <= '0;
        end else begin
            if (wen0 && (waddr0 != '0)) begin
                regs[waddr0] <= wdata0;
                busy[waddr0] <= 1'b0;
            end
            if (wen1 && (waddr1 != '0)) begin
                regs[waddr1] <= wdata1;
                busy[waddr1] <= 1'b0;
            end
            if (iss_en && (iss_addr != '0)) begin
                busy[iss_addr] <= 1'b1;
            end
        end
    end

    // One read port instance per decode operand
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .raddr    (raddr[p*ADDR_W +: ADDR_W]),
            .regs     (regs),
            .busy     (busy),
`ifdef REGFILE_BYPASS_EN
            .wen0     (wen0),
            .waddr0   (waddr0),
            .wdata0   (wdata0),
            .wen1     (wen1),
            .waddr1   (waddr1),
            .wdata1   (wdata1),
            .iss_en   (iss_en),
            .iss_addr (iss_addr),
`endif
            .rdata    (rdata[p*DATA_W +: DATA_W]),
            .rbusy    (rbusy[p])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed steps followed by randomized cycles
// compared against an array-based reference model of registers and busy bits.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic              wen0, wen1, iss_en;
    logic [AW-1:0]     waddr0, waddr1, iss_addr;
    logic [DW-1:0]     wdata0, wdata1;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];

    regfile_mp dut (
        .CLK      (CLK),
        .RST      (RST),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .wen0     (wen0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .wen1     (wen1),
        .waddr1   (waddr1),
        .wdata1   (wdata1),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read value for address a given current inputs and model contents
    function automatic logic [DW-1:0] exp_data(input int a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
        if (wen0 && int'(waddr0) == a) v = wdata0;
        if (wen1 && int'(waddr1) == a) v = wdata1;
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if ((wen0 && int'(waddr0) == a) || (wen1 && int'(waddr1) == a))
            return iss_en && int'(iss_addr) == a;
`endif
        return m_busy[a];
    endfunction

    // Apply one clock edge to the model, then advance the DUT past the edge
    task automatic tick();
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = (i == 29) ? 32'hfff : 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wen0 && waddr0 != 0) begin m_regs[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
            if (wen1 && waddr1 != 0) begin m_regs[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RST = 0; wen0 = 0; wen1 = 0; iss_en = 0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_addr = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        raddr[0*AW +: AW] = AW'(a0);
        raddr[1*AW +: AW] = AW'(a1);
    endtask

    // Compare every read port against the model
    task automatic chk_model(input string tag);
        int a;
        #1;
        for (int p = 0; p < NR; p++) begin
            a = int'(raddr[p*AW +: AW]);
            chk({tag, "_data"}, rdata[p*DW +: DW], exp_data(a));
            chk({tag, "_busy"}, DW'(rbusy[p]), DW'(exp_busy(a)));
        end
    endtask

    initial begin
        reg_addr_t ra;
        idle();
        set_rd(0, 0);
        for (int i = 0; i < DEPTH; i++) begin m_regs[i] = 'x; m_busy[i] = 1'bx; end

        // Reset
        RST = 1; tick(); RST = 0;
        set_rd(29, 5); #1;
        chk("rst_sp", rdata[0 +: DW], 32'hfff);
        chk("rst_r5", rdata[DW +: DW], 32'h0);
        chk("rst_busy", DW'(rbusy), 32'h0);

        // Reset dominates a same-cycle write
        wen0 = 1; waddr0 = 5; wdata0 = 7; tick(); idle();
        wen0 = 1; waddr0 = 5; wdata0 = 7; RST = 1; tick(); idle();
        set_rd(5, 29); #1;
        chk("rst_dom_r5", rdata[0 +: DW], 32'h0);
        chk("rst_dom_sp", rdata[DW +: DW], 32'hfff);

        // Register 0 is hardwired
        wen0 = 1; waddr0 = 0; wdata0 = 32'hdead; tick(); idle();
        set_rd(0, 0); #1;
        chk("r0_p0", rdata[0 +: DW], 32'h0);
        chk("r0_p1", rdata[DW +: DW], 32'h0);

        // Plain write, both ports read it
        wen0 = 1; waddr0 = 3; wdata0 = 42; tick(); idle();
        set_rd(3, 3); #1;
        chk("w3_p0", rdata[0 +: DW], 32'd42);
        chk("w3_p1", rdata[DW +: DW], 32'd42);

        // Same-address collision: port 1 wins
        wen0 = 1; waddr0 = 7; wdata0 = 1; wen1 = 1; waddr1 = 7; wdata1 = 2; tick(); idle();
        set_rd(7, 3); #1;
        chk("coll_r7", rdata[0 +: DW], 32'd2);

        // Scoreboard set / clear / issue-wins
        iss_en = 1; iss_addr = 8; tick(); idle();
        set_rd(8, 8); #1;
        chk("sb_set", DW'(rbusy), 32'h3);
        wen0 = 1; waddr0 = 8; wdata0 = 5; tick(); idle(); #1;
        chk("sb_clr", DW'(rbusy), 32'h0);
        wen1 = 1; waddr1 = 8; wdata1 = 6; iss_en = 1; iss_addr = 8; tick(); idle(); #1;
        chk("sb_iss_wins", DW'(rbusy), 32'h3);
        chk("sb_iss_data", rdata[0 +: DW], 32'd6);

        // Same-cycle read of a register being written
        wen0 = 1; waddr0 = 4; wdata0 = 9; tick(); idle();
        set_rd(4, 0);
        wen1 = 1; waddr1 = 4; wdata1 = 11; #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same", rdata[0 +: DW], 32'd11);
`else
        chk("byp_same", rdata[0 +: DW], 32'd9);
`endif
        tick(); idle(); #1;
        chk("byp_next", rdata[0 +: DW], 32'd11);

        // Randomized cycles against the model
        for (int n = 0; n < 2000; n++) begin
            RST    = ($urandom_range(0, 99) == 0);
            wen0   = $urandom_range(0, 1) == 1;
            wen1   = $urandom_range(0, 2) == 0;
            iss_en = $urandom_range(0, 2) == 0;
            ra = reg_addr_t'($urandom_range(0, 7)); waddr0 = ra;
            ra = reg_addr_t'($urandom_range(0, 7)); waddr1 = ($urandom_range(0, 1) == 1) ? ra : AW'($urandom());
            ra = reg_addr_t'($urandom_range(0, 7)); iss_addr = ($urandom_range(0, 1) == 1) ? ra : AW'($urandom());
            wdata0 = $urandom();
            wdata1 = $urandom();
            set_rd($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31),
                   $urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : 29);
            chk_model("rand");
            tick();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
